myproject_sdiv_26s_10ns_16_seq: RTL

MYPROJECT_SDIV_26S_10NS_16_SEQ -- requirements
Module: myproject_sdiv_26s_10ns_16_seq

---
 rtl/myproject_sdiv_26s_10ns_16_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/myproject_sdiv_26s_10ns_16_seq.sv
// myproject_sdiv_26s_10ns_16_seq: sequential signed-by-unsigned restoring divider, one quotient bit per cycle; define MYPROJECT_SDIV_SAT_EN for saturating dout with ovf flag
module myproject_sdiv_26s_10ns_16_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  dz
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(din0_WIDTH + 1);
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [din0_WIDTH-1:0]   r_dvd;
  logic [din1_WIDTH-1:0]   r_rem, r_dvs;
  logic                    r_neg, r_ovf, r_dz;
  logic [dout_WIDTH-1:0]   r_dout;
  logic                    w_last, w_dz, w_ovf;
  logic [din0_WIDTH-1:0]   w_abs, w_q, w_sq;
  logic [din1_WIDTH:0]     w_sh;
  logic [din1_WIDTH+1:0]   w_sub;
  logic [din1_WIDTH-1:0]   w_rem;
  logic [dout_WIDTH-1:0]   w_dout;
  assign w_last    = r_cnt == CW'(din0_WIDTH - 1);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign dout      = r_dout;
  assign ovf       = r_ovf;
  assign dz        = r_dz;
  assign w_abs     = din0[din0_WIDTH-1] ? -din0 : din0;
  // partial remainder stays below the divisor, so the trial difference needs one extra sign bit
  assign w_sh      = {r_rem, r_dvd[din0_WIDTH-1]};
  assign w_sub     = {1'b0, w_sh} - {2'b00, r_dvs};
  assign w_rem     = w_sub[din1_WIDTH+1] ? w_sh[din1_WIDTH-1:0] : w_sub[din1_WIDTH-1:0];
  assign w_q       = {r_dvd[din0_WIDTH-2:0], ~w_sub[din1_WIDTH+1]};
  assign w_sq      = r_neg ? -w_q : w_q;
  assign w_dz      = r_dvs == '0;
`ifdef MYPROJECT_SDIV_SAT_EN
  localparam logic [din0_WIDTH-1:0] LIM  = din0_WIDTH'(2 ** (dout_WIDTH - 1) - 1);
  localparam logic [dout_WIDTH-1:0] MAXV = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] MINV = {1'b1, {(dout_WIDTH-1){1'b0}}};
  assign w_ovf  = !w_dz && (r_neg ? w_q > LIM + 1'b1 : w_q > LIM);
  assign w_dout = (w_dz || w_ovf) ? (r_neg ? MINV : MAXV) : w_sq[dout_WIDTH-1:0];
`else
  assign w_ovf  = 1'b0;
  assign w_dout = w_dz ? '0 : w_sq[dout_WIDTH-1:0];
`endif
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? CALC : IDLE;
      CALC:    w_next = w_last ? DONE : CALC;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_neg  <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_cnt <= '0;
      r_dvd <= w_abs;
      r_rem <= '0;
      r_dvs <= din1;
      r_neg <= din0[din0_WIDTH-1];
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_dvd <= w_q;
      r_rem <= w_rem;
      if (w_last) begin
        r_dout <= w_dout;
        r_ovf  <= w_ovf;
        r_dz   <= w_dz;
      end
    end
endmodule
